// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised CPU register file.
// Default geometry matches the classic 32x32 two-read/one-write file.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 32;
  localparam int REGFILE_DEPTH = 32;

  // Ceiling log2; DEPTH is a power of two so this is exact.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, write bypass, zero-register
// override and operand-ready generation from the pending scoreboard.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [AW-1:0]                readRegister,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
  input  logic [DEPTH-1:0]             pending,
  input  logic                         writeEnable,
  input  logic [AW-1:0]                writeRegister,
  input  logic [WIDTH-1:0]             writeData,
  output logic [WIDTH-1:0]             readData,
  output logic                         ready
);

  logic isZeroReg;
  logic bypassHit;

  assign isZeroReg = (ZERO_REG != 0) && (readRegister == '0);
  assign bypassHit = (BYPASS != 0) && writeEnable && (writeRegister == readRegister);

  // Zero register has the final say so a bypass can never leak into it.
  always_comb begin
    readData = regs[readRegister];
    ready    = !pending[readRegister];
    if (bypassHit) begin
      readData = writeData;
      ready    = 1'b1;
    end
    if (isZeroReg) begin
      readData = '0;
      ready    = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with optional write bypass
// and a per-register pending scoreboard for operand-ready stalls.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [AW-1:0]     ReadRegister1,
  input  logic [AW-1:0]     ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              Ready1,
  output logic              Ready2,
  input  logic [AW-1:0]     WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic [AW-1:0]     ReserveRegister,
  input  logic              Reserve
);

  logic [DEPTH-1:0][WIDTH-1:0] regsReg;
  logic [DEPTH-1:0]            pendingReg;
  logic [DEPTH-1:0]            writeHit;
  logic [DEPTH-1:0]            reserveHit;
  logic                        bypassEnable;

  // Per-register decode; register 0 never decodes when it is hardwired.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : genDecode
    if ((ZERO_REG != 0) && (gi == 0)) begin : genZero
      assign writeHit[gi]   = 1'b0;
      assign reserveHit[gi] = 1'b0;
    end else begin : genNormal
      assign writeHit[gi]   = RegWrite && (WriteRegister == AW'(gi));
      assign reserveHit[gi] = Reserve && (ReserveRegister == AW'(gi));
    end
  end

  // Reserve is applied after the write clear: a new producer wins.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      regsReg    <= '0;
      pendingReg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (writeHit[i]) begin
          regsReg[i] <= WriteData;
        end
      end
      pendingReg <= reserveHit | (pendingReg & ~writeHit);
    end
  end

  // A write held during reset is discarded, so it must not forward either.
  assign bypassEnable = RegWrite && ResetN;

  regfile_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) readPort1 (
    .readRegister  (ReadRegister1),
    .regs          (regsReg),
    .pending       (pendingReg),
    .writeEnable   (bypassEnable),
    .writeRegister (WriteRegister),
    .writeData     (WriteData),
    .readData      (ReadData1),
    .ready         (Ready1)
  );

  regfile_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) readPort2 (
    .readRegister  (ReadRegister2),
    .regs          (regsReg),
    .pending       (pendingReg),
    .writeEnable   (bypassEnable),
    .writeRegister (WriteRegister),
    .writeData     (WriteData),
    .readData      (ReadData2),
    .ready         (Ready2)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed test-plan cases plus randomized traffic on
// two builds (zero-reg+bypass, plain) checked against an array-based model.
module tb_regfile_param;
  import regfile_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = clog2(DEPTH);

  logic              Clk = 1'b0;
  logic              ResetN = 1'b1;
  logic [AW-1:0]     ReadRegister1 = '0;
  logic [AW-1:0]     ReadRegister2 = '0;
  logic [AW-1:0]     WriteRegister = '0;
  logic [AW-1:0]     ReserveRegister = '0;
  logic [WIDTH-1:0]  WriteData = '0;
  logic              RegWrite = 1'b0;
  logic              Reserve = 1'b0;

  logic [WIDTH-1:0]  readDataA1, readDataA2, readDataB1, readDataB2;
  logic              readyA1, readyA2, readyB1, readyB2;

  int checkCount = 0;
  int errorCount = 0;
  int txnCount   = 0;

  // Model state, index 0 = build A (ZERO_REG=1,BYPASS=1), 1 = build B (0,0).
  logic [WIDTH-1:0]  modelMem [2][DEPTH];
  bit                modelPend [2][DEPTH];
  bit                cfgZero [2]   = '{1'b1, 1'b0};
  bit                cfgBypass [2] = '{1'b1, 1'b0};

  always #5 Clk = ~Clk;

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(1)) dutA (
    .Clk(Clk), .ResetN(ResetN),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(readDataA1), .ReadData2(readDataA2),
    .Ready1(readyA1), .Ready2(readyA2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReserveRegister(ReserveRegister), .Reserve(Reserve)
  );

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(0), .BYPASS(0)) dutB (
    .Clk(Clk), .ResetN(ResetN),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(readDataB1), .ReadData2(readDataB2),
    .Ready1(readyB1), .Ready2(readyB2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReserveRegister(ReserveRegister), .Reserve(Reserve)
  );

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] expData(input int c, input logic [AW-1:0] a);
    if (cfgZero[c] && a == 0) return '0;
    if (cfgBypass[c] && ResetN && RegWrite && WriteRegister == a) return WriteData;
    return modelMem[c][a];
  endfunction

  function automatic logic expReady(input int c, input logic [AW-1:0] a);
    if (cfgZero[c] && a == 0) return 1'b1;
    if (cfgBypass[c] && ResetN && RegWrite && WriteRegister == a) return 1'b1;
    return !modelPend[c][a];
  endfunction

  task automatic clearModel();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < DEPTH; r++) begin
        modelMem[c][r]  = '0;
        modelPend[c][r] = 1'b0;
      end
    end
  endtask

  // Edge semantics: write (clears pending), then reserve sets pending.
  task automatic updateModel();
    for (int c = 0; c < 2; c++) begin
      if (RegWrite && !(cfgZero[c] && WriteRegister == 0)) begin
        modelMem[c][WriteRegister]  = WriteData;
        modelPend[c][WriteRegister] = 1'b0;
      end
      if (Reserve && !(cfgZero[c] && ReserveRegister == 0)) begin
        modelPend[c][ReserveRegister] = 1'b1;
      end
    end
  endtask

  task automatic checkAll(input string where);
    checkValue({where, ":A.data1"},  readDataA1, expData(0, ReadRegister1));
    checkValue({where, ":A.data2"},  readDataA2, expData(0, ReadRegister2));
    checkValue({where, ":A.ready1"}, readyA1,    expReady(0, ReadRegister1));
    checkValue({where, ":A.ready2"}, readyA2,    expReady(0, ReadRegister2));
    checkValue({where, ":B.data1"},  readDataB1, expData(1, ReadRegister1));
    checkValue({where, ":B.data2"},  readDataB2, expData(1, ReadRegister2));
    checkValue({where, ":B.ready1"}, readyB1,    expReady(1, ReadRegister1));
    checkValue({where, ":B.ready2"}, readyB2,    expReady(1, ReadRegister2));
  endtask

  task automatic setInputs(input logic we, input int wa, input logic [WIDTH-1:0] wd,
                           input logic rsv, input int ra, input int r1, input int r2);
    RegWrite        = we;
    WriteRegister   = AW'(wa);
    WriteData       = wd;
    Reserve         = rsv;
    ReserveRegister = AW'(ra);
    ReadRegister1   = AW'(r1);
    ReadRegister2   = AW'(r2);
  endtask

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic step(input string where);
    #2;
    if (!ResetN) clearModel();
    checkAll(where);
    @(posedge Clk);
    if (ResetN) updateModel();
    @(negedge Clk);
    txnCount++;
    $display("txn %0d %s rstn=%0d we=%0d wa=%0d wd=%h rsv=%0d ra=%0d r1=%0d r2=%0d",
             txnCount, where, ResetN, RegWrite, WriteRegister, WriteData,
             Reserve, ReserveRegister, ReadRegister1, ReadRegister2);
  endtask

  task automatic idleRead(input int r1, input int r2);
    setInputs(1'b0, 0, '0, 1'b0, 0, r1, r2);
    #1;
  endtask

  function automatic int randAddr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, DEPTH - 1));
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    clearModel();
    setInputs(1'b0, 0, '0, 1'b0, 0, 5, 31);

    // Reset
    #1 ResetN = 1'b0;
    #1;
    checkValue("rst_low.A.data1", readDataA1, 32'd0);
    checkValue("rst_low.A.ready2", readyA2, 1'b1);
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    #1;
    checkValue("rst.A.data1", readDataA1, 32'd0);
    checkValue("rst.A.data2", readDataA2, 32'd0);
    checkValue("rst.B.ready1", readyB1, 1'b1);
    checkValue("rst.B.ready2", readyB2, 1'b1);
    step("reset");

    // Write / read
    setInputs(1'b1, 2, 32'd42, 1'b0, 0, 2, 2);
    step("wr42");
    idleRead(2, 2);
    checkValue("wr42.A.data1", readDataA1, 32'd42);
    checkValue("wr42.A.data2", readDataA2, 32'd42);
    checkValue("wr42.B.data1", readDataB1, 32'd42);
    setInputs(1'b1, 2, 32'd15, 1'b0, 0, 2, 2);
    step("wr15");
    setInputs(1'b1, 3, 32'd7, 1'b0, 0, 2, 3);
    step("wr7");
    idleRead(2, 3);
    checkValue("wr7.A.data1", readDataA1, 32'd15);
    checkValue("wr7.A.data2", readDataA2, 32'd7);

    // Zero register
    setInputs(1'b1, 0, 32'hDEADBEEF, 1'b0, 0, 0, 0);
    step("wr0");
    idleRead(0, 0);
    checkValue("zero.A.data1", readDataA1, 32'd0);
    checkValue("zero.B.data1", readDataB1, 32'hDEADBEEF);

    // Bypass before the edge, then the committed value after it
    setInputs(1'b1, 9, 32'h1234, 1'b0, 0, 9, 9);
    #1;
    checkValue("byp.A.data1", readDataA1, 32'h1234);
    checkValue("byp.A.ready1", readyA1, 1'b1);
    checkValue("byp.B.data1_pre", readDataB1, 32'd0);
    step("byp");
    idleRead(9, 9);
    checkValue("byp.B.data1_post", readDataB1, 32'h1234);

    // Scoreboard
    setInputs(1'b0, 0, '0, 1'b1, 4, 4, 4);
    step("rsv4");
    idleRead(4, 4);
    checkValue("rsv4.A.ready1", readyA1, 1'b0);
    checkValue("rsv4.B.ready1", readyB1, 1'b0);
    setInputs(1'b1, 4, 32'd99, 1'b0, 0, 4, 4);
    step("wr99");
    idleRead(4, 4);
    checkValue("wr99.A.ready1", readyA1, 1'b1);
    checkValue("wr99.A.data1", readDataA1, 32'd99);
    setInputs(1'b1, 4, 32'd77, 1'b1, 4, 4, 4);
    step("wr77rsv");
    idleRead(4, 4);
    checkValue("wr77rsv.A.data1", readDataA1, 32'd77);
    checkValue("wr77rsv.A.ready1", readyA1, 1'b0);
    checkValue("wr77rsv.B.ready1", readyB1, 1'b0);

    // Async reset between edges; the write presented during reset is lost
    setInputs(1'b1, 2, 32'h5555, 1'b0, 0, 2, 4);
    ResetN = 1'b0;
    #1;
    checkValue("arst.A.data1", readDataA1, 32'd0);
    checkValue("arst.A.data2", readDataA2, 32'd0);
    checkValue("arst.A.ready2", readyA2, 1'b1);
    checkValue("arst.B.ready2", readyB2, 1'b1);
    step("arst");
    ResetN = 1'b1;
    idleRead(2, 4);
    checkValue("arst_lost.A.data1", readDataA1, 32'd0);
    checkValue("arst_lost.B.data1", readDataB1, 32'd0);
    checkValue("arst_lost.B.ready2", readyB2, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      ResetN = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      setInputs(logic'($urandom_range(0, 1)), randAddr(), WIDTH'($urandom),
                logic'($urandom_range(0, 2) == 0), randAddr(), randAddr(), randAddr());
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
